// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: 8b/10b decode with running-disparity checking and
// the receive state machine driving registered GMII RXD/RX_DV/RX_ER.
module pcs_receive (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic [9:0] rx_code_group,
  input  logic       sync_status,
  output logic [7:0] RXD,
  output logic       RX_DV,
  output logic       RX_ER,
  output logic       receiving,
  output logic       rx_even,
  output logic       rx_disp_err
);

  typedef enum logic [2:0] {
    StLinkFailed, StWaitForK, StRxK, StIdleD, StReceive, StTrrExtend
  } state_e;

  state_e     state_q;
  logic       rd_q;  // running disparity, 1 = positive
  logic [7:0] rxd_q;
  logic       rx_dv_q, rx_er_q, rx_even_q, rx_disp_err_q;

  logic [5:0] c6;
  logic [3:0] c4;
  logic [2:0] ones6, ones4;
  logic [4:0] x6;
  logic [2:0] y4;
  logic       v6, k28_6, v4, a7, a7_ok, p7_bad;
  logic       rd_mid, rd_end, d6_ok, d4_ok, disp_ok;
  logic       is_k285, is_k7, is_s, is_t, is_r, is_data, err;
  logic [7:0] octet;

  // Table decode of both sub-blocks plus disparity legality for the current RD
  always_comb begin
    c6     = rx_code_group[9:4];
    c4     = rx_code_group[3:0];
    ones6  = 3'($countones(c6));
    ones4  = 3'($countones(c4));
    x6     = 5'd0;
    v6     = 1'b1;
    k28_6  = 1'b0;
    unique case (c6)
      6'b100111, 6'b011000: x6 = 5'd0;
      6'b011101, 6'b100010: x6 = 5'd1;
      6'b101101, 6'b010010: x6 = 5'd2;
      6'b110001:            x6 = 5'd3;
      6'b110101, 6'b001010: x6 = 5'd4;
      6'b101001:            x6 = 5'd5;
      6'b011001:            x6 = 5'd6;
      6'b111000, 6'b000111: x6 = 5'd7;
      6'b111001, 6'b000110: x6 = 5'd8;
      6'b100101:            x6 = 5'd9;
      6'b010101:            x6 = 5'd10;
      6'b110100:            x6 = 5'd11;
      6'b001101:            x6 = 5'd12;
      6'b101100:            x6 = 5'd13;
      6'b011100:            x6 = 5'd14;
      6'b010111, 6'b101000: x6 = 5'd15;
      6'b011011, 6'b100100: x6 = 5'd16;
      6'b100011:            x6 = 5'd17;
      6'b010011:            x6 = 5'd18;
      6'b110010:            x6 = 5'd19;
      6'b001011:            x6 = 5'd20;
      6'b101010:            x6 = 5'd21;
      6'b011010:            x6 = 5'd22;
      6'b111010, 6'b000101: x6 = 5'd23;
      6'b110011, 6'b001100: x6 = 5'd24;
      6'b100110:            x6 = 5'd25;
      6'b010110:            x6 = 5'd26;
      6'b110110, 6'b001001: x6 = 5'd27;
      6'b001110:            x6 = 5'd28;
      6'b101110, 6'b010001: x6 = 5'd29;
      6'b011110, 6'b100001: x6 = 5'd30;
      6'b101011, 6'b010100: x6 = 5'd31;
      6'b001111, 6'b110000: begin x6 = 5'd28; k28_6 = 1'b1; end
      default:              v6 = 1'b0;
    endcase

    y4 = 3'd0;
    v4 = 1'b1;
    a7 = 1'b0;
    unique case (c4)
      4'b1011, 4'b0100: y4 = 3'd0;
      4'b1001:          y4 = 3'd1;
      4'b0101:          y4 = 3'd2;
      4'b1100, 4'b0011: y4 = 3'd3;
      4'b1101, 4'b0010: y4 = 3'd4;
      4'b1010:          y4 = 3'd5;
      4'b0110:          y4 = 3'd6;
      4'b1110, 4'b0001: y4 = 3'd7;
      4'b0111, 4'b1000: begin y4 = 3'd7; a7 = 1'b1; end
      default:          v4 = 1'b0;
    endcase

    // D.x.7 must use the alternate form exactly where the primary would form a run of five
    a7_ok  = (c4 == 4'b0111 && (x6 inside {5'd17, 5'd18, 5'd20})) ||
             (c4 == 4'b1000 && (x6 inside {5'd11, 5'd13, 5'd14}));
    p7_bad = (c4 == 4'b1110 && (x6 inside {5'd17, 5'd18, 5'd20})) ||
             (c4 == 4'b0001 && (x6 inside {5'd11, 5'd13, 5'd14}));

    // Neutral D7 and x.3 sub-blocks are still tied to one RD polarity
    d6_ok  = (ones6 == 3'd4 && !rd_q) || (ones6 == 3'd2 && rd_q) ||
             (ones6 == 3'd3 && !(c6 == 6'b111000 && rd_q) && !(c6 == 6'b000111 && !rd_q));
    rd_mid = (ones6 == 3'd4) ? 1'b1 : (ones6 == 3'd2) ? 1'b0 : rd_q;
    d4_ok  = (ones4 == 3'd3 && !rd_mid) || (ones4 == 3'd1 && rd_mid) ||
             (ones4 == 3'd2 && !(c4 == 4'b1100 && rd_mid) && !(c4 == 4'b0011 && !rd_mid));
    rd_end = (ones4 == 3'd3) ? 1'b1 : (ones4 == 3'd1) ? 1'b0 : rd_mid;
    disp_ok = d6_ok && d4_ok;

    is_k285 = k28_6 && ((c6 == 6'b001111 && c4 == 4'b1010) ||
                        (c6 == 6'b110000 && c4 == 4'b0101));
    is_k7   = v6 && !k28_6 && a7 && (x6 inside {5'd23, 5'd27, 5'd29, 5'd30});
    is_s    = is_k7 && x6 == 5'd27;
    is_t    = is_k7 && x6 == 5'd29;
    is_r    = is_k7 && x6 == 5'd23;
    is_data = v6 && !k28_6 && v4 && (a7 ? a7_ok : !p7_bad);
    err     = !(is_data || is_k285 || is_k7) || !disp_ok;
    octet   = {y4, x6};
  end

  // Receive state machine with registered GMII outputs and RD tracking
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q       <= StLinkFailed;
      rd_q          <= 1'b0;
      rxd_q         <= 8'h00;
      rx_dv_q       <= 1'b0;
      rx_er_q       <= 1'b0;
      rx_even_q     <= 1'b0;
      rx_disp_err_q <= 1'b0;
    end else begin
      rd_q          <= rd_end;
      rx_even_q     <= is_k285 | ~rx_even_q;
      // A K28.5 of either polarity is a legitimate resync point while hunting for comma
      rx_disp_err_q <= sync_status && state_q != StLinkFailed && err &&
                       !(state_q == StWaitForK && is_k285);
      rxd_q         <= 8'h00;
      rx_dv_q       <= 1'b0;
      rx_er_q       <= 1'b0;
      if (!sync_status) begin
        state_q <= StLinkFailed;
        rx_er_q <= (state_q == StReceive);
      end else begin
        unique case (state_q)
          StLinkFailed: state_q <= StWaitForK;
          StWaitForK:   if (is_k285) state_q <= StRxK;
          StRxK:        state_q <= (is_data && disp_ok) ? StIdleD : StWaitForK;
          StIdleD: begin
            if (is_k285) begin
              state_q <= StRxK;
            end else if (is_s && disp_ok) begin
              state_q <= StReceive;
              rxd_q   <= 8'h55;
              rx_dv_q <= 1'b1;
            end else begin
              state_q <= StWaitForK;
              rxd_q   <= 8'h0E;
              rx_er_q <= 1'b1;
            end
          end
          StReceive: begin
            if (is_k285) begin
              state_q <= StRxK;
              rx_er_q <= 1'b1;
            end else if (is_t && disp_ok) begin
              state_q <= StTrrExtend;
            end else if (is_data && disp_ok) begin
              rxd_q   <= octet;
              rx_dv_q <= 1'b1;
            end else begin
              rx_dv_q <= 1'b1;
              rx_er_q <= 1'b1;
            end
          end
          StTrrExtend: begin
            if (is_r && disp_ok) state_q <= StTrrExtend;
            else if (is_k285)    state_q <= StRxK;
            else                 state_q <= StWaitForK;
          end
          default: state_q <= StLinkFailed;
        endcase
      end
    end
  end

  assign RXD         = rxd_q;
  assign RX_DV       = rx_dv_q;
  assign RX_ER       = rx_er_q;
  assign receiving   = (state_q == StReceive);
  assign rx_even     = rx_even_q;
  assign rx_disp_err = rx_disp_err_q;

endmodule
